fetch_sequencer: RTL and testbench

- Instruction-fetch controller that drives the system-bus request/response ports on behalf of the decode stage.
- Fetches one 64-byte line per bus transaction: 8 beats of 64 bits.
- Buffers the line and presents 32-bit instructions, lowest address first, over a valid/ready handshake.
- Supports redirect of the fetch PC and halts on an all-zero instruction word.

---
 rtl/fetch_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: pulls 64-byte lines over the system bus, buffers
// them, and hands 32-bit instructions to decode lowest address first.
`ifndef SYSBUS_READ
`define SYSBUS_READ 1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 1
`endif

module fetch_sequencer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    output logic [31:0]               inst_data,
    output logic [63:0]               inst_pc,
    output logic                      halted
);

    localparam int BEATS          = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int WORDS          = LINE_BYTES / 4;
    localparam int WORDS_PER_BEAT = BUS_DATA_WIDTH / 32;
    localparam int CNT_W          = $clog2(BEATS);
    localparam int OFF_W          = $clog2(LINE_BYTES);
    localparam int REQ_TAG        = (`SYSBUS_READ << 12) | (`SYSBUS_MEMORY << 8);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_ISSUE, S_HALT} state_t;

    state_t                    state_reg;
    logic [63:0]               pc_reg;
    logic [63:0]               pending_pc_reg;
    logic [CNT_W-1:0]          count_reg;
    logic                      discard_reg;
    logic [BUS_DATA_WIDTH-1:0] line_buf [BEATS];
    logic [31:0]               words [WORDS];
    logic [63:0]               redirect_pc_aligned;
    logic [63:0]               pc_next;
    logic [31:0]               cur_word;
    logic [31:0]               next_word;
    logic                      unused_bits;

    function automatic logic [BUS_DATA_WIDTH-1:0] line_addr(input logic [63:0] a);
        return BUS_DATA_WIDTH'({a[63:OFF_W], OFF_W'(0)});
    endfunction

    assign bus_reqtag          = REQ_TAG[BUS_TAG_WIDTH-1:0];
    assign redirect_pc_aligned = {redirect_pc[63:2], 2'b00};
    assign pc_next             = pc_reg + 64'd4;
    assign cur_word            = words[pc_reg[OFF_W-1:2]];
    assign next_word           = words[pc_next[OFF_W-1:2]];
    assign unused_bits         = ^{bus_resptag, entry[1:0], redirect_pc[1:0]};

    // Low half of each beat holds the lower-addressed instruction.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign words[gi] = line_buf[gi / WORDS_PER_BEAT][32 * (gi % WORDS_PER_BEAT) +: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset && state_reg == S_RESP && bus_respcyc) begin
            line_buf[count_reg] <= bus_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            pc_reg         <= {entry[63:2], 2'b00};
            pending_pc_reg <= '0;
            count_reg      <= '0;
            discard_reg    <= 1'b0;
            bus_reqcyc     <= 1'b0;
            bus_req        <= '0;
            bus_respack    <= 1'b0;
            inst_valid     <= 1'b0;
            inst_data      <= '0;
            inst_pc        <= '0;
            halted         <= 1'b0;
        end else begin
            bus_respack <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    state_reg  <= S_REQ;
                    bus_reqcyc <= 1'b1;
                    if (redirect_valid) begin
                        pc_reg  <= redirect_pc_aligned;
                        bus_req <= line_addr(redirect_pc_aligned);
                    end else begin
                        bus_req <= line_addr(pc_reg);
                    end
                end
                S_REQ: begin
                    if (bus_reqack) begin
                        // A redirect racing the ack turns this line into a discard.
                        bus_reqcyc     <= 1'b0;
                        state_reg      <= S_RESP;
                        count_reg      <= '0;
                        discard_reg    <= redirect_valid;
                        pending_pc_reg <= redirect_pc_aligned;
                    end else if (redirect_valid) begin
                        pc_reg  <= redirect_pc_aligned;
                        bus_req <= line_addr(redirect_pc_aligned);
                    end
                end
                S_RESP: begin
                    if (redirect_valid) begin
                        discard_reg    <= 1'b1;
                        pending_pc_reg <= redirect_pc_aligned;
                    end
                    if (bus_respcyc) begin
                        count_reg   <= count_reg + CNT_W'(1);
                        bus_respack <= 1'b1;
                        if (count_reg == CNT_W'(BEATS - 1)) begin
                            if (discard_reg || redirect_valid) begin
                                pc_reg      <= redirect_valid ? redirect_pc_aligned : pending_pc_reg;
                                bus_req     <= line_addr(redirect_valid ? redirect_pc_aligned
                                                                        : pending_pc_reg);
                                bus_reqcyc  <= 1'b1;
                                discard_reg <= 1'b0;
                                state_reg   <= S_REQ;
                            end else begin
                                state_reg <= S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (redirect_valid) begin
                        pc_reg     <= redirect_pc_aligned;
                        inst_valid <= 1'b0;
                        bus_reqcyc <= 1'b1;
                        bus_req    <= line_addr(redirect_pc_aligned);
                        state_reg  <= S_REQ;
                    end else if (!inst_valid) begin
                        // First cycle after the line lands: present the entry word.
                        if (cur_word == 32'h0) begin
                            halted    <= 1'b1;
                            state_reg <= S_HALT;
                        end else begin
                            inst_valid <= 1'b1;
                            inst_data  <= cur_word;
                            inst_pc    <= pc_reg;
                        end
                    end else if (inst_ready) begin
                        pc_reg <= pc_next;
                        if (pc_reg[OFF_W-1:2] == '1) begin
                            inst_valid <= 1'b0;
                            bus_reqcyc <= 1'b1;
                            bus_req    <= line_addr(pc_next);
                            state_reg  <= S_REQ;
                        end else if (next_word == 32'h0) begin
                            inst_valid <= 1'b0;
                            halted     <= 1'b1;
                            state_reg  <= S_HALT;
                        end else begin
                            inst_data <= next_word;
                            inst_pc   <= pc_next;
                        end
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-plus-random bench for fetch_sequencer; memory contents are a pure
// function of address so expected instructions follow from the fetch PC alone.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .entry(entry),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .halted(halted)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] seed;
    logic        zero_en;
    logic [63:0] zero_addr;
    logic [63:0] exp_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (zero_en && a == zero_addr) return 32'h0;
        return ((a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ seed) | 32'h1;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
        logic [63:0] a;
        a = line + 64'(8 * b);
        return {mem_word(a + 64'd4), mem_word(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [63:0] e);
        reset = 1'b0;
        entry = e;
        repeat (2) begin
            step();
            chk1("rst_reqcyc", bus_reqcyc, 1'b0);
            chk("rst_req", bus_req, 64'h0);
            chk1("rst_respack", bus_respack, 1'b0);
            chk1("rst_inst_valid", inst_valid, 1'b0);
            chk1("rst_halted", halted, 1'b0);
        end
        reset = 1'b1;
        entry = {$urandom, $urandom};
        $display("[TB] reset with entry %h", e);
    endtask

    task automatic wait_req(input logic [63:0] exp_addr);
        int n;
        n = 0;
        while (bus_reqcyc !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk1("req_seen", bus_reqcyc, 1'b1);
        chk1("req_no_inst", inst_valid, 1'b0);
        chk("req_addr", bus_req, exp_addr);
        chk("req_tag", 64'(bus_reqtag), 64'h1100);
        repeat ($urandom_range(0, 3)) begin
            step();
            chk1("req_hold_cyc", bus_reqcyc, 1'b1);
            chk("req_hold_addr", bus_req, exp_addr);
        end
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        chk1("req_drop", bus_reqcyc, 1'b0);
        $display("[TB] request line %h accepted", exp_addr);
    endtask

    task automatic send_beats(input logic [63:0] line, input int first, input int last,
                              input int redir_after, input logic [63:0] rpc, output int acks);
        acks = 0;
        for (int b = first; b <= last; b++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                acks += int'(bus_respack === 1'b1);
            end
            bus_respcyc = 1'b1;
            bus_resp    = beat_data(line, b);
            step();
            bus_respcyc = 1'b0;
            bus_resp    = {$urandom, $urandom};
            acks += int'(bus_respack === 1'b1);
            if (b == redir_after) begin
                redirect_valid = 1'b1;
                redirect_pc    = rpc;
                step();
                redirect_valid = 1'b0;
                acks += int'(bus_respack === 1'b1);
            end
        end
        $display("[TB] line %h beats %0d..%0d sent, %0d acks", line, first, last, acks);
    endtask

    task automatic consume(input int n, input bit pattern);
        for (int k = 0; k < n; k++) begin
            int w;
            int stall;
            w = 0;
            while (inst_valid !== 1'b1 && w < 32) begin
                inst_ready = 1'($urandom);
                step();
                w++;
            end
            inst_ready = 1'b0;
            chk1("inst_valid", inst_valid, 1'b1);
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", 64'(inst_data), 64'(mem_word(exp_pc)));
            stall = pattern ? ((k == 1) ? 2 : 0) : int'($urandom_range(0, 2));
            repeat (stall) begin
                step();
                chk1("stall_valid", inst_valid, 1'b1);
                chk("stall_data", 64'(inst_data), 64'(mem_word(exp_pc)));
                chk("stall_pc", inst_pc, exp_pc);
            end
            inst_ready = 1'b1;
            step();
            inst_ready = 1'b0;
            $display("[TB] inst pc=%h data=%h stall=%0d", exp_pc, mem_word(exp_pc), stall);
            exp_pc = exp_pc + 64'd4;
        end
    endtask

    initial begin
        int          acks;
        int          n;
        logic [63:0] rpc;
        seed           = $urandom;
        zero_en        = 1'b0;
        zero_addr      = 64'h0;
        exp_pc         = 64'h0;
        reset          = 1'b0;
        entry          = 64'h0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = 64'h0;
        bus_resptag    = 13'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;

        // Entry, backpressure, sequential line crossing.
        do_reset(64'h1008);
        wait_req(64'h1000);
        send_beats(64'h1000, 0, 7, -1, 64'h0, acks);
        chk("line_acks", 64'(acks), 64'd8);
        exp_pc = 64'h1008;
        consume(14, 1'b1);
        wait_req(64'h1040);

        // Redirect during RESP: old line drained and dropped.
        send_beats(64'h1040, 0, 7, 3, 64'h2004, acks);
        chk("discard_acks", 64'(acks), 64'd8);
        wait_req(64'h2000);
        send_beats(64'h2000, 0, 7, -1, 64'h0, acks);
        chk("redir_line_acks", 64'(acks), 64'd8);
        exp_pc = 64'h2004;
        consume(3, 1'b0);

        // Zero word halts; halt is sticky and ignores redirects and bus traffic.
        do_reset(64'h1008);
        zero_en   = 1'b1;
        zero_addr = 64'h1010;
        wait_req(64'h1000);
        send_beats(64'h1000, 0, 7, -1, 64'h0, acks);
        chk("zero_line_acks", 64'(acks), 64'd8);
        exp_pc = 64'h1008;
        consume(2, 1'b0);
        chk1("halted", halted, 1'b1);
        chk1("halt_no_inst", inst_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 5);
            redirect_pc    = 64'h3000;
            bus_respcyc    = 1'(i % 2);
            step();
            chk1("halt_no_req", bus_reqcyc, 1'b0);
            chk1("halt_no_ack", bus_respack, 1'b0);
            chk1("halt_sticky", halted, 1'b1);
        end
        redirect_valid = 1'b0;
        bus_respcyc    = 1'b0;
        zero_en        = 1'b0;

        // Redirect coinciding with a handshake at 0x1020, into the top line.
        do_reset(64'h1008);
        wait_req(64'h1000);
        send_beats(64'h1000, 0, 7, -1, 64'h0, acks);
        chk("sim_line_acks", 64'(acks), 64'd8);
        exp_pc = 64'h1008;
        consume(6, 1'b0);
        n = 0;
        while (inst_valid !== 1'b1 && n < 32) begin
            step();
            n++;
        end
        chk("sim_pc", inst_pc, 64'h1020);
        rpc            = 64'hFFFF_FFFF_FFFF_FFC0 | 64'($urandom_range(0, 63));
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk1("sim_no_inst", inst_valid, 1'b0);
        wait_req(64'hFFFF_FFFF_FFFF_FFC0);
        send_beats(64'hFFFF_FFFF_FFFF_FFC0, 0, 7, -1, 64'h0, acks);
        chk("top_line_acks", 64'(acks), 64'd8);
        exp_pc = rpc & ~64'h3;
        consume(16 - int'(exp_pc[5:2]), 1'b0);
        wait_req(64'h0);

        // Reset after beat 2: no acks for the abandoned beats.
        send_beats(64'h0, 0, 2, -1, 64'h0, acks);
        chk("partial_acks", 64'(acks), 64'd3);
        bus_respcyc = 1'b1;
        bus_resp    = beat_data(64'h0, 3);
        do_reset(64'h4000);
        step();
        chk1("rst_no_late_ack", bus_respack, 1'b0);
        step();
        chk1("rst_no_late_ack2", bus_respack, 1'b0);
        bus_respcyc = 1'b0;
        chk1("post_rst_reqcyc", bus_reqcyc, 1'b1);
        chk("post_rst_req", bus_req, 64'h4000);

        // Redirect while the request is still waiting for ack.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5008;
        step();
        redirect_valid = 1'b0;
        chk1("reqredir_cyc", bus_reqcyc, 1'b1);
        chk("reqredir_addr", bus_req, 64'h5000);
        wait_req(64'h5000);
        send_beats(64'h5000, 0, 7, -1, 64'h0, acks);
        chk("final_line_acks", 64'(acks), 64'd8);
        exp_pc = 64'h5008;
        consume(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
